// File: rtl/seg7_hex_capture_if.sv
// Segment/digit-enable sampling bus plus the captured-digit outputs of seg7_hex_capture.
// The display side is the master; the capture block is the slave.
interface seg7_hex_capture_if #(
  parameter int DIGITS = 4
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [6:0]          seg;
  logic [DIGITS-1:0]   dig_en;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   lit;
  logic                upd;
  logic [IDX_W-1:0]    upd_idx;
  logic                err;
  logic                frame;

  modport master (
    output seg, dig_en,
    input  value, lit, upd, upd_idx, err, frame
  );

  modport slave (
    input  seg, dig_en,
    output value, lit, upd, upd_idx, err, frame
  );
endinterface

// File: rtl/seg7_hex_capture.sv
// Re-encodes stable 7-segment patterns from a multiplexed display bus into per-digit
// nibbles, with update/error pulses and a frame pulse once every digit has been written.
module seg7_hex_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                resetn,
  seg7_hex_capture_if.slave   bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW    = (STABLE_CYCLES > 0) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam int SW    = DIGITS + 7;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]       r_s;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_lit;
  logic [DIGITS-1:0]   r_seen;
  logic                r_upd;
  logic [IDX_W-1:0]    r_upd_idx;
  logic                r_err;
  logic                r_frame;

  logic [SW-1:0]       w_in;
  logic [DIGITS-1:0]   w_dig;
  logic [DIGITS-1:0]   w_seen_nxt;
  logic [IDX_W-1:0]    w_idx;
  logic [3:0]          w_nib;
  logic                w_hex;
  logic                w_blank;
  logic                w_onehot;
  logic                w_accept;

  assign w_in       = {bus.dig_en, bus.seg};
  assign w_dig      = r_s[SW-1:7];
  assign w_onehot   = ($countones(w_dig) == 1);
  assign w_accept   = (w_in == r_s) && (r_cnt == CNT_ACC);
  assign w_seen_nxt = r_seen | w_dig;

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_dig[k]) w_idx = IDX_W'(k);
    end
  end

  // Decode uses the registered pattern, which equals the input on the accept edge.
  always_comb begin
    w_hex   = 1'b1;
    w_blank = 1'b0;
    w_nib   = 4'h0;
    case (r_s[6:0])
      7'b1111110: w_nib = 4'h0;
      7'b0000110: w_nib = 4'h1;
      7'b1101101: w_nib = 4'h2;
      7'b1001111: w_nib = 4'h3;
      7'b0010111: w_nib = 4'h4;
      7'b1011011: w_nib = 4'h5;
      7'b1111011: w_nib = 4'h6;
      7'b0001110: w_nib = 4'h7;
      7'b1111111: w_nib = 4'h8;
      7'b1011111: w_nib = 4'h9;
      7'b0111111: w_nib = 4'hA;
      7'b1110011: w_nib = 4'hB;
      7'b1111000: w_nib = 4'hC;
      7'b1100111: w_nib = 4'hD;
      7'b1111001: w_nib = 4'hE;
      7'b0111001: w_nib = 4'hF;
      7'b0000000: begin
        w_hex   = 1'b0;
        w_blank = 1'b1;
      end
      default:    w_hex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s       <= '0;
      r_cnt     <= '0;
      r_value   <= '0;
      r_lit     <= '0;
      r_seen    <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
      r_err     <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
      r_frame <= 1'b0;

      // Saturating count means a held pattern fires exactly once.
      if (w_in != r_s) begin
        r_s   <= w_in;
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_accept && w_onehot) begin
        if (w_hex || w_blank) begin
          for (int k = 0; k < DIGITS; k++) begin
            if (w_dig[k]) begin
              if (w_hex) r_value[4*k +: 4] <= w_nib;
              r_lit[k] <= w_hex;
            end
          end
          r_upd     <= 1'b1;
          r_upd_idx <= w_idx;
          // The completing write closes the frame and is not carried into the next one.
          if (&w_seen_nxt) begin
            r_frame <= 1'b1;
            r_seen  <= '0;
          end else begin
            r_seen  <= w_seen_nxt;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.value   = r_value;
  assign bus.lit     = r_lit;
  assign bus.upd     = r_upd;
  assign bus.upd_idx = r_upd_idx;
  assign bus.err     = r_err;
  assign bus.frame   = r_frame;
endmodule

// File: tb/tb_seg7_hex_capture.sv
// Scoreboard bench: directed segment patterns push expected pulses into a queue,
// monitors pop and compare on every upd/err pulse, including the pulse cycle.
module tb_seg7_hex_capture;
  localparam int SC1 = 4;
  localparam int SC2 = 1;

  localparam logic [1:0] K_UPD = 2'b10;
  localparam logic [1:0] K_ERR = 2'b01;

  typedef struct {
    logic [1:0]  kind;
    int          idx;
    logic [15:0] value;
    logic [3:0]  lit;
    logic        frame;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q1[$];
  exp_t q2[$];

  seg7_hex_capture_if #(.DIGITS(4)) b1 ();
  seg7_hex_capture_if #(.DIGITS(1)) b2 ();

  seg7_hex_capture #(.DIGITS(4), .STABLE_CYCLES(SC1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(b1.slave)
  );
  seg7_hex_capture #(.DIGITS(1), .STABLE_CYCLES(SC2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(b2.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn && (b1.upd || b1.err)) begin
      if (q1.size() == 0) begin
        chk("d1_unexpected_pulse", {30'd0, b1.upd, b1.err}, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("d1_kind",  {30'd0, b1.upd, b1.err}, {30'd0, e.kind});
        chk("d1_cycle", cyc, e.cyc);
        chk("d1_idx",   {30'd0, b1.upd_idx}, e.idx);
        chk("d1_value", {16'd0, b1.value}, {16'd0, e.value});
        chk("d1_lit",   {28'd0, b1.lit}, {28'd0, e.lit});
        chk("d1_frame", {31'd0, b1.frame}, {31'd0, e.frame});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (resetn && (b2.upd || b2.err)) begin
      if (q2.size() == 0) begin
        chk("d2_unexpected_pulse", {30'd0, b2.upd, b2.err}, 32'd0);
      end else begin
        e = q2.pop_front();
        chk("d2_kind",  {30'd0, b2.upd, b2.err}, {30'd0, e.kind});
        chk("d2_cycle", cyc, e.cyc);
        chk("d2_idx",   {31'd0, b2.upd_idx}, e.idx);
        chk("d2_value", {28'd0, b2.value}, {28'd0, e.value[3:0]});
        chk("d2_lit",   {31'd0, b2.lit}, {31'd0, e.lit[0]});
        chk("d2_frame", {31'd0, b2.frame}, {31'd0, e.frame});
      end
    end
  end

  // Applies a pattern at a falling edge and holds it for 'hold' cycles.
  task automatic step(input logic [3:0] d, input logic [6:0] s, input int hold,
                      input logic [1:0] kind, input int idx, input logic [15:0] v,
                      input logic [3:0] l, input logic fr);
    exp_t e;
    @(negedge clk);
    b1.dig_en = d;
    b1.seg    = s;
    if (kind != 2'b00) begin
      e = '{kind: kind, idx: idx, value: v, lit: l, frame: fr, cyc: cyc + SC1 + 1};
      q1.push_back(e);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_value"},   {16'd0, b1.value}, 32'd0);
    chk({tag, "_lit"},     {28'd0, b1.lit}, 32'd0);
    chk({tag, "_upd"},     {31'd0, b1.upd}, 32'd0);
    chk({tag, "_upd_idx"}, {30'd0, b1.upd_idx}, 32'd0);
    chk({tag, "_err"},     {31'd0, b1.err}, 32'd0);
    chk({tag, "_frame"},   {31'd0, b1.frame}, 32'd0);
  endtask

  initial begin
    exp_t e;
    b1.dig_en = '0;
    b1.seg    = '0;
    b2.dig_en = '0;
    b2.seg    = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single-digit, single-cycle-stability instance
    @(negedge clk);
    b2.dig_en = 1'b1;
    b2.seg    = 7'b1110011;
    e = '{kind: K_UPD, idx: 0, value: 16'hB, lit: 4'h1, frame: 1'b1, cyc: cyc + SC2 + 1};
    q2.push_back(e);
    repeat (6) @(negedge clk);
    b2.seg = 7'b0000000;
    e = '{kind: K_UPD, idx: 0, value: 16'hB, lit: 4'h0, frame: 1'b1, cyc: cyc + SC2 + 1};
    q2.push_back(e);
    repeat (4) @(negedge clk);
    b2.seg = 7'b1000001;
    e = '{kind: K_ERR, idx: 0, value: 16'hB, lit: 4'h0, frame: 1'b0, cyc: cyc + SC2 + 1};
    q2.push_back(e);
    repeat (4) @(negedge clk);
    b2.dig_en = 1'b0;
    b2.seg    = 7'b0000000;

    // Digit 0 shows '2', then held long with no repeat pulse
    step(4'b0001, 7'b1101101, 25, K_UPD, 0, 16'h0002, 4'b0001, 1'b0);
    // Scan 1,2,3,F across digits 0..3; frame on the last
    step(4'b0001, 7'b0000110, 6, K_UPD, 0, 16'h0001, 4'b0001, 1'b0);
    step(4'b0010, 7'b1101101, 6, K_UPD, 1, 16'h0021, 4'b0011, 1'b0);
    step(4'b0100, 7'b1001111, 6, K_UPD, 2, 16'h0321, 4'b0111, 1'b0);
    step(4'b1000, 7'b0111001, 6, K_UPD, 3, 16'hF321, 4'b1111, 1'b1);
    // Invalid pattern then blank on digit 1
    step(4'b0010, 7'b1000001, 6, K_ERR, 3, 16'hF321, 4'b1111, 1'b0);
    step(4'b0010, 7'b0000000, 6, K_UPD, 1, 16'hF321, 4'b1101, 1'b0);
    // Unstable and multi-hot inputs must stay silent
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 7'b0000110, 3, 2'b00, 0, 16'h0, 4'h0, 1'b0);
      step(4'b0001, 7'b1101101, 3, 2'b00, 0, 16'h0, 4'h0, 1'b0);
    end
    step(4'b0011, 7'b1111110, 10, 2'b00, 0, 16'h0, 4'h0, 1'b0);

    // Reset while a run on digit 2 has cnt=2
    @(negedge clk);
    b1.dig_en = 4'b0100;
    b1.seg    = 7'b0010111;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    resetn = 1'b1;
    e = '{kind: K_UPD, idx: 2, value: 16'h0400, lit: 4'b0100, frame: 1'b0, cyc: cyc + SC1 + 1};
    q1.push_back(e);
    repeat (7) @(negedge clk);

    // Re-show the same pattern after an intervening change, then complete a frame
    step(4'b0000, 7'b0000000, 6, 2'b00, 0, 16'h0, 4'h0, 1'b0);
    step(4'b0100, 7'b0010111, 6, K_UPD, 2, 16'h0400, 4'b0100, 1'b0);
    step(4'b0001, 7'b1111111, 6, K_UPD, 0, 16'h0408, 4'b0101, 1'b0);
    step(4'b0010, 7'b0111111, 6, K_UPD, 1, 16'h04A8, 4'b0111, 1'b0);
    step(4'b1000, 7'b1111000, 6, K_UPD, 3, 16'hC4A8, 4'b1111, 1'b1);
    step(4'b0000, 7'b0000000, 10, 2'b00, 0, 16'h0, 4'h0, 1'b0);

    chk("d1_missing_pulses", q1.size(), 32'd0);
    chk("d2_missing_pulses", q2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
